// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 line bundle for the host transmitter
interface ps2_host_tx_if;
  logic [7:0] data_i;
  logic send_i;
  logic busy_o;
  logic done_o;
  logic error_o;
  logic ps2_clk_i;
  logic ps2_data_i;
  logic ps2_clk_oe_o;
  logic ps2_data_oe_o;
  modport master (
    output data_i, send_i, ps2_clk_i, ps2_data_i,
    input busy_o, done_o, error_o, ps2_clk_oe_o, ps2_data_oe_o
  );
  modport slave (
    input data_i, send_i, ps2_clk_i, ps2_data_i,
    output busy_o, done_o, error_o, ps2_clk_oe_o, ps2_data_oe_o
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, framing, ack check and timeout
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input logic clock_i,
  input logic reset_i,
  ps2_host_tx_if.slave bus
);
  localparam int INH = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TMO = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W = $clog2(INH + 1);
  localparam int TMO_W = $clog2(TMO + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, filt;
  logic [2:0] h [2];
  logic clk_d, fell, expired;
  logic [INH_W-1:0] icnt;
  logic [TMO_W-1:0] tcnt;
  logic [8:0] sh;
  logic [3:0] bcnt;
  logic done_q, err_q, done_n, err_n, clk_oe, data_oe;
  assign fell = clk_d & ~filt[0];
  assign expired = tcnt == TMO_W'(TMO - 1);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      s1 <= '1;
      s2 <= '1;
      h <= '{3'b111, 3'b111};
      filt <= '1;
      clk_d <= 1'b1;
      icnt <= '0;
      tcnt <= '0;
      sh <= '0;
      bcnt <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      s1 <= {bus.ps2_data_i, bus.ps2_clk_i};
      s2 <= s1;
      clk_d <= filt[0];
      done_q <= done_n;
      err_q <= err_n;
      // a line level is accepted only after four matching synchronized samples
      for (int k = 0; k < 2; k++) begin
        h[k] <= {h[k][1:0], s2[k]};
        filt[k] <= (&{h[k], s2[k]}) ? 1'b1 : (|{h[k], s2[k]}) ? filt[k] : 1'b0;
      end
      icnt <= (state == INHIBIT) ? icnt + 1'b1 : '0;
      tcnt <= (state == REQ || state == BITS || state == ACK) ? tcnt + 1'b1 : '0;
      bcnt <= (state == BITS) ? (fell ? bcnt + 1'b1 : bcnt) : '0;
      if (state == IDLE && bus.send_i)
        sh <= {~^bus.data_i, bus.data_i};
      else if (state == BITS && fell)
        sh <= sh >> 1;
    end
  end
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    err_n = 1'b0;
    clk_oe = 1'b0;
    data_oe = 1'b0;
    case (state)
      IDLE: state_n = bus.send_i ? INHIBIT : IDLE;
      INHIBIT: begin
        clk_oe = 1'b1;
        data_oe = icnt == INH_W'(INH - 1);
        state_n = data_oe ? REQ : INHIBIT;
      end
      REQ: begin
        data_oe = 1'b1;
        err_n = expired;
        state_n = expired ? IDLE : fell ? BITS : REQ;
      end
      BITS: begin
        data_oe = ~sh[0];
        err_n = expired;
        state_n = expired ? IDLE : (fell && bcnt == 4'd8) ? ACK : BITS;
      end
      ACK: begin
        // stop bit is the released line; device answers on the next falling edge
        done_n = ~expired & fell & ~filt[1];
        err_n = expired | (fell & filt[1]);
        state_n = expired ? IDLE : fell ? WAIT_IDLE : ACK;
      end
      WAIT_IDLE: state_n = (&filt) ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = done_q;
  assign bus.error_o = err_q;
  assign bus.ps2_clk_oe_o = clk_oe;
  assign bus.ps2_data_oe_o = data_oe;
endmodule
